// File: rtl/bf16_pkg.sv
// bf16_pkg: shared types and constants for the bfloat16 add/subtract datapath.
//   bf16_t        packed bfloat16 view {sign, exp[7:0], frac[6:0]}
//   BF16_*        canonical quiet NaN and signed infinities
//   EXP_BIAS      exponent bias (127)
//   FLAG_*        bit positions inside the 4-bit {NV, OF, UF, NX} flag vector
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam logic [15:0] BF16_NINF = 16'hFF80;
    localparam int          EXP_BIAS  = 127;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

endpackage

// File: rtl/bf16_lzc.sv
// bf16_lzc: 11-bit leading-zero counter used to renormalize after an
// effective subtraction.
//   din    11-bit significand (hidden bit at [10], G/R/S at [2:0])
//   count  number of leading zeros, 0..11 (11 only for an all-zero input)
module bf16_lzc (
    input  logic [10:0] din,
    output logic [3:0]  count
);

    // Ascending scan: the highest set bit is visited last and wins.
    always_comb begin
        count = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (din[i]) count = 4'(10 - i);
        end
    end

endmodule

// File: rtl/caravel_bf16_addsub.sv
// caravel_bf16_addsub: pipelined bfloat16 adder/subtractor, round-to-nearest-even,
// subnormal inputs flushed to signed zero.
//   clock      rising-edge clock
//   reset      synchronous active-high reset (clears valids, result, flags)
//   in_valid   operands valid this cycle (one operation per cycle, no backpressure)
//   op         0 = a+b, 1 = a-b
//   a, b       bfloat16 operands
//   out_valid  result/flags valid
//   result     bfloat16 result (holds while out_valid is low)
//   flags      {NV, OF, UF, NX}
// Optional build macro BF16_PIPE_EN inserts a register between normalization
// and rounding (latency 3 instead of 2).
module caravel_bf16_addsub
    import bf16_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] result,
    output logic [3:0]  flags
);

`ifdef BF16_PIPE_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif
    localparam logic signed [9:0] EXP_MAX = 10'(2 * EXP_BIAS + 1);

    // Returns {result[15:0], flags[3:0]} for a normalized significand
    // (hidden bit at [10], guard/round/sticky at [2:0]).
    function automatic logic [19:0] round_rne(input logic              sign,
                                              input logic signed [9:0] exp,
                                              input logic [10:0]       sig);
        logic [8:0]        mant;
        logic signed [9:0] e;
        logic              up;
        logic [15:0]       res;
        logic [3:0]        fl;
        up   = sig[2] & (sig[1] | sig[0] | sig[3]);
        mant = {1'b0, sig[10:3]} + 9'(up);
        e    = exp;
        if (mant[8]) begin
            mant = mant >> 1;
            e    = e + 10'sd1;
        end
        fl          = '0;
        fl[FLAG_NX] = |sig[2:0];
        if (exp <= 10'sd0) begin
            res         = {sign, 15'h0000};
            fl[FLAG_UF] = 1'b1;
            fl[FLAG_NX] = 1'b1;
        end else if (e >= EXP_MAX) begin
            res         = sign ? BF16_NINF : BF16_PINF;
            fl[FLAG_OF] = 1'b1;
            fl[FLAG_NX] = 1'b1;
        end else begin
            res = {sign, e[7:0], mant[6:0]};
        end
        return {res, fl};
    endfunction

    // ---- stage 0: unpack, special cases, swap and align ----
    bf16_t       ua_p0, ub_p0, big_p0, small_p0;
    logic        a_nan_p0, b_nan_p0, a_inf_p0, b_inf_p0, a_zero_p0, b_zero_p0;
    logic        byp_p0;
    logic [15:0] byp_res_p0;
    logic [3:0]  byp_flags_p0;
    logic [7:0]  exp_diff_p0;
    logic [3:0]  sh_amt_p0;
    logic [21:0] sh_p0;
    logic [10:0] small_sig_p0;

    assign ua_p0     = bf16_t'(a);
    assign ub_p0     = bf16_t'({b[15] ^ op, b[14:0]});
    assign a_nan_p0  = (&ua_p0.exp) & (|ua_p0.frac);
    assign b_nan_p0  = (&ub_p0.exp) & (|ub_p0.frac);
    assign a_inf_p0  = (&ua_p0.exp) & ~(|ua_p0.frac);
    assign b_inf_p0  = (&ub_p0.exp) & ~(|ub_p0.frac);
    assign a_zero_p0 = (ua_p0.exp == 8'h00);
    assign b_zero_p0 = (ub_p0.exp == 8'h00);

    always_comb begin
        byp_p0       = 1'b1;
        byp_res_p0   = 16'h0000;
        byp_flags_p0 = 4'h0;
        if (a_nan_p0 | b_nan_p0) begin
            byp_res_p0            = BF16_QNAN;
            byp_flags_p0[FLAG_NV] = (a_nan_p0 & ~ua_p0.frac[6]) | (b_nan_p0 & ~ub_p0.frac[6]);
        end else if (a_inf_p0 & b_inf_p0) begin
            if (ua_p0.sign != ub_p0.sign) begin
                byp_res_p0            = BF16_QNAN;
                byp_flags_p0[FLAG_NV] = 1'b1;
            end else begin
                byp_res_p0 = ua_p0;
            end
        end else if (a_inf_p0) begin
            byp_res_p0 = ua_p0;
        end else if (b_inf_p0) begin
            byp_res_p0 = ub_p0;
        end else if (a_zero_p0 & b_zero_p0) begin
            byp_res_p0 = {ua_p0.sign & ub_p0.sign, 15'h0000};
        end else if (a_zero_p0) begin
            byp_res_p0 = ub_p0;
        end else if (b_zero_p0) begin
            byp_res_p0 = ua_p0;
        end else begin
            byp_p0 = 1'b0;
        end
    end

    always_comb begin
        big_p0       = ua_p0;
        small_p0     = ub_p0;
        if (ub_p0[14:0] > ua_p0[14:0]) begin
            big_p0   = ub_p0;
            small_p0 = ua_p0;
        end
        exp_diff_p0  = big_p0.exp - small_p0.exp;
        sh_amt_p0    = (exp_diff_p0 > 8'd10) ? 4'd10 : exp_diff_p0[3:0];
        // Bits falling off the low end collapse into the sticky position.
        sh_p0        = {1'b1, small_p0.frac, 3'b000, 11'h000} >> sh_amt_p0;
        small_sig_p0 = {sh_p0[21:12], sh_p0[11] | (|sh_p0[10:0])};
    end

    // ---- stage 1 registers: aligned operands ----
    logic        sign_p1, eff_sub_p1, byp_p1;
    logic [7:0]  exp_p1;
    logic [10:0] big_sig_p1, small_sig_p1;
    logic [15:0] byp_res_p1;
    logic [3:0]  byp_flags_p1;

    always_ff @(posedge clock) begin
        sign_p1      <= big_p0.sign;
        eff_sub_p1   <= ua_p0.sign ^ ub_p0.sign;
        exp_p1       <= big_p0.exp;
        big_sig_p1   <= {1'b1, big_p0.frac, 3'b000};
        small_sig_p1 <= small_sig_p0;
        byp_p1       <= byp_p0;
        byp_res_p1   <= byp_res_p0;
        byp_flags_p1 <= byp_flags_p0;
    end

    // ---- stage 1: add/subtract and normalize ----
    logic [11:0]       sum_p1;
    logic [10:0]       diff_p1, nrm_sig_p1;
    logic [3:0]        lz_p1;
    logic signed [9:0] nrm_exp_p1;
    logic              nrm_byp_p1;
    logic [15:0]       nrm_byp_res_p1;

    assign sum_p1  = {1'b0, big_sig_p1} + {1'b0, small_sig_p1};
    assign diff_p1 = big_sig_p1 - small_sig_p1;

    bf16_lzc u_lzc (
        .din   (diff_p1),
        .count (lz_p1)
    );

    always_comb begin
        nrm_sig_p1     = sum_p1[10:0];
        nrm_exp_p1     = $signed({2'b00, exp_p1});
        nrm_byp_p1     = byp_p1;
        nrm_byp_res_p1 = byp_res_p1;
        if (eff_sub_p1) begin
            nrm_sig_p1 = diff_p1 << lz_p1;
            nrm_exp_p1 = $signed({2'b00, exp_p1}) - $signed({6'b000000, lz_p1});
            // Exact cancellation yields +0 regardless of operand signs.
            if (!byp_p1 && diff_p1 == 11'h000) begin
                nrm_byp_p1     = 1'b1;
                nrm_byp_res_p1 = 16'h0000;
            end
        end else if (sum_p1[11]) begin
            nrm_sig_p1 = {sum_p1[11:2], sum_p1[1] | sum_p1[0]};
            nrm_exp_p1 = $signed({2'b00, exp_p1}) + 10'sd1;
        end
    end

    logic              rnd_sign, rnd_byp;
    logic signed [9:0] rnd_exp;
    logic [10:0]       rnd_sig;
    logic [15:0]       rnd_byp_res;
    logic [3:0]        rnd_byp_flags;

`ifdef BF16_PIPE_EN
    // ---- stage 2 registers: normalized sum ----
    always_ff @(posedge clock) begin
        rnd_sign      <= sign_p1;
        rnd_exp       <= nrm_exp_p1;
        rnd_sig       <= nrm_sig_p1;
        rnd_byp       <= nrm_byp_p1;
        rnd_byp_res   <= nrm_byp_res_p1;
        rnd_byp_flags <= byp_flags_p1;
    end
`else
    assign rnd_sign      = sign_p1;
    assign rnd_exp       = nrm_exp_p1;
    assign rnd_sig       = nrm_sig_p1;
    assign rnd_byp       = nrm_byp_p1;
    assign rnd_byp_res   = nrm_byp_res_p1;
    assign rnd_byp_flags = byp_flags_p1;
`endif

    // ---- final stage: round and register outputs ----
    logic [19:0]        rnd_out;
    logic [LATENCY-1:0] vld_p;

    assign rnd_out   = round_rne(rnd_sign, rnd_exp, rnd_sig);
    assign out_valid = vld_p[LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p  <= '0;
            result <= 16'h0000;
            flags  <= 4'h0;
        end else begin
            vld_p <= {vld_p[LATENCY-2:0], in_valid};
            if (vld_p[LATENCY-2]) begin
                result <= rnd_byp ? rnd_byp_res   : rnd_out[19:4];
                flags  <= rnd_byp ? rnd_byp_flags : rnd_out[3:0];
            end
        end
    end

endmodule

// File: tb/tb_caravel_bf16_addsub.sv
// tb_caravel_bf16_addsub: directed, table-driven bench for caravel_bf16_addsub,
// plus back-to-back throughput and reset-in-flight sequences.
module tb_caravel_bf16_addsub;

`ifdef BF16_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int NVEC = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic [15:0] result;
    logic [3:0]  flags;

    caravel_bf16_addsub dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] res;
        logic [3:0]  fl;   // {NV, OF, UF, NX}
    } vec_t;

    vec_t vecs [NVEC];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int cycles;
        @(negedge clock);
        a        = vecs[i].a;
        b        = vecs[i].b;
        op       = vecs[i].op;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        cycles   = 1;
        while (!out_valid && cycles < 10) begin
            @(negedge clock);
            cycles++;
        end
        check("latency", i, cycles, LAT);
        check("result", i, {16'h0, result}, {16'h0, vecs[i].res});
        check("flags", i, {28'h0, flags}, {28'h0, vecs[i].fl});
        @(negedge clock);
        check("valid_drop", i, {31'h0, out_valid}, 32'h0);
        check("result_hold", i, {16'h0, result}, {16'h0, vecs[i].res});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'h0};  // 1+2
        vecs[1]  = '{16'h3F80, 16'h4000, 1'b1, 16'hBF80, 4'h0};  // 1-2
        vecs[2]  = '{16'h4040, 16'h4040, 1'b1, 16'h0000, 4'h0};  // exact cancel -> +0
        vecs[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0};  // -0 + -0
        vecs[4]  = '{16'h0000, 16'h5823, 1'b1, 16'hD823, 4'h0};  // 0 - x
        vecs[5]  = '{16'hDCD9, 16'h0000, 1'b0, 16'hDCD9, 4'h0};  // x + 0
        vecs[6]  = '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'h1};  // tie, even stays
        vecs[7]  = '{16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 4'h1};  // tie, odd rounds up
        vecs[8]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 4'h5};  // overflow
        vecs[9]  = '{16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 4'h8};  // inf - inf
        vecs[10] = '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 4'h0};  // quiet NaN
        vecs[11] = '{16'h7F80, 16'hC000, 1'b0, 16'h7F80, 4'h0};  // inf + finite
        vecs[12] = '{16'h7F81, 16'h3F80, 1'b0, 16'h7FC0, 4'h8};  // signaling NaN
        vecs[13] = '{16'h0080, 16'h0081, 1'b1, 16'h8000, 4'h3};  // underflow to -0
        vecs[14] = '{16'h3FFF, 16'h3B80, 1'b0, 16'h4000, 4'h1};  // rounding carry renormalizes
        vecs[15] = '{16'hBF80, 16'hC000, 1'b0, 16'hC040, 4'h0};  // -1 + -2
        vecs[16] = '{16'h0001, 16'h3F80, 1'b0, 16'h3F80, 4'h0};  // subnormal flushed
        vecs[17] = '{16'hC000, 16'h3F80, 1'b0, 16'hBF80, 4'h0};  // -2 + 1
        vecs[18] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 4'h0};  // +0 + -0
        vecs[19] = '{16'h4000, 16'h3F80, 1'b1, 16'h3F80, 4'h0};  // 2 - 1

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_valid", 0, {31'h0, out_valid}, 32'h0);
        check("rst_result", 0, {16'h0, result}, 32'h0);
        check("rst_flags", 0, {28'h0, flags}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Back-to-back: four operations on consecutive cycles
        begin
            int idx [4];
            idx = '{0, 7, 15, 19};
            for (int c = 0; c < LAT + 7; c++) begin
                @(negedge clock);
                if (c >= 1) begin
                    check("b2b_valid", c, {31'h0, out_valid},
                          {31'h0, (c >= LAT && c < LAT + 4) ? 1'b1 : 1'b0});
                    if (c >= LAT && c < LAT + 4)
                        check("b2b_result", c, {16'h0, result}, {16'h0, vecs[idx[c - LAT]].res});
                end
                if (c < 4) begin
                    a        = vecs[idx[c]].a;
                    b        = vecs[idx[c]].b;
                    op       = vecs[idx[c]].op;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end

        // Reset with operations in flight
        @(negedge clock);
        a = 16'h3F80; b = 16'h4000; op = 1'b0; in_valid = 1'b1;
        @(negedge clock);
        a = 16'h7F7F; b = 16'h7F7F;
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("flush_valid", c, {31'h0, out_valid}, 32'h0);
            check("flush_result", c, {16'h0, result}, 32'h0);
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
